// File: rtl/uart_tb_pkg.sv
// -----------------------------------------------------------------------------
// uart_tb_pkg
// Shared definitions for the bench-side UART receiver (uart_rx_capture):
//   - state_t  : receiver FSM state encoding
//   - ASCII_LF : line-feed byte counted by the receiver's line counter
// -----------------------------------------------------------------------------
package uart_tb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    localparam logic [7:0] ASCII_LF = 8'h0A;

endpackage

// File: rtl/uart_rx_capture_if.sv
// -----------------------------------------------------------------------------
// uart_rx_capture_if
// Byte stream from the UART receiver FIFO to its consumer.
//   m_data  : head-of-FIFO byte, meaningful only while m_valid = 1
//   m_valid : FIFO holds at least one byte
//   m_ready : consumer takes the head byte
// Handshake: a byte moves on every rising clk edge where m_valid & m_ready
// are both 1. m_valid does not depend on m_ready; m_ready while m_valid = 0
// has no effect. The next byte (if any) appears the cycle after the transfer.
// -----------------------------------------------------------------------------
interface uart_rx_capture_if;

    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;

    // Receiver side drives data/valid.
    modport master (
        output m_data,
        output m_valid,
        input  m_ready
    );

    // Consumer side drives ready.
    modport slave (
        input  m_data,
        input  m_valid,
        output m_ready
    );

endinterface

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// Synchronous show-ahead FIFO. The head entry is presented combinationally
// from registered storage; pop advances to the next entry at the clock edge.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (empties the FIFO)
//   push       : write push_data (accepted if not full, or if popping now)
//   push_data  : WIDTH-bit write data
//   pop        : remove head entry (ignored while empty)
//   head       : current head entry
//   full/empty : occupancy flags
//   level      : occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit: equal addresses with differing wrap
    // bits means full, fully equal means empty.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign do_pop  = pop & ~empty;
    // When full, a same-cycle pop frees the head slot, which is exactly the
    // slot the write pointer addresses.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    assign head  = mem[rd_ptr[AW-1:0]];
    assign level = wr_ptr - rd_ptr;

endmodule

// File: rtl/uart_rx_capture.sv
// -----------------------------------------------------------------------------
// uart_rx_capture
// Bench-side 8N1 UART receiver for the SoC UART0 TX pin. Decodes frames
// oversampled at CLKS_PER_BIT clocks per bit and queues good bytes in a
// show-ahead FIFO drained over a valid/ready interface.
// Parameters:
//   CLKS_PER_BIT : clocks per bit, even, >= 8
//   FIFO_DEPTH   : byte FIFO entries, power of two, >= 2
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   rxd        : asynchronous serial input, idle high
//   clr        : clears overflow and line_cnt (FIFO untouched)
//   m          : byte stream (m_data / m_valid / m_ready)
//   frame_err  : one-cycle pulse when a stop bit samples 0
//   overflow   : sticky, a good byte was dropped on a full FIFO
//   fifo_level : FIFO occupancy
//   line_cnt   : number of 0x0A bytes written to the FIFO (wraps)
//   fsm_state  : receiver FSM state, for observation
// -----------------------------------------------------------------------------
module uart_rx_capture
    import uart_tb_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rxd,
    input  logic                          clr,
    uart_rx_capture_if.master             m,
    output logic                          frame_err,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   line_cnt,
    output state_t                        fsm_state
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);

    // ------------------------------------------------------------------
    // Input synchronizer (idles high so reset does not look like a start)
    // ------------------------------------------------------------------
    logic sync1;
    logic rxs;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= rxd;
            rxs   <= sync1;
        end
    end

    // ------------------------------------------------------------------
    // Receiver FSM
    // ------------------------------------------------------------------
    state_t        state;
    state_t        next_state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_reg;
    logic          cnt_zero;

    // Control strobes from the output process
    logic load_half;
    logic load_full;
    logic shift_en;
    logic stop_sample;

    assign cnt_zero  = (baud_cnt == '0);
    assign fsm_state = state;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (!rxs) next_state = ST_START;
            ST_START: if (cnt_zero) next_state = rxs ? ST_IDLE : ST_DATA;
            ST_DATA:  if (cnt_zero && bit_idx == 3'd7) next_state = ST_STOP;
            ST_STOP:  if (cnt_zero) next_state = rxs ? ST_IDLE : ST_BREAK;
            ST_BREAK: if (rxs) next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Output / control logic
    always_comb begin
        load_half   = 1'b0;
        load_full   = 1'b0;
        shift_en    = 1'b0;
        stop_sample = 1'b0;
        case (state)
            ST_IDLE:  load_half = ~rxs;
            ST_START: load_full = cnt_zero & ~rxs;
            ST_DATA: begin
                shift_en  = cnt_zero;
                // The reload after bit 7 times the stop-bit sample.
                load_full = cnt_zero;
            end
            ST_STOP:  stop_sample = cnt_zero;
            default: ;
        endcase
    end

    // Baud counter, bit index and shift register
    always_ff @(posedge clk) begin
        if (rst) begin
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
        end else begin
            if (load_half)      baud_cnt <= HALF_LOAD;
            else if (load_full) baud_cnt <= FULL_LOAD;
            else if (!cnt_zero) baud_cnt <= baud_cnt - CW'(1);

            if (load_half)     bit_idx <= '0;
            else if (shift_en) bit_idx <= bit_idx + 3'd1;

            // LSB arrives first, so shift in from the top.
            if (shift_en) shift_reg <= {rxs, shift_reg[7:1]};
        end
    end

    // ------------------------------------------------------------------
    // Frame completion register. Good and bad frames both resolve one
    // cycle after the stop sample, so frame_err lines up with the cycle
    // m_valid would rise for a good frame.
    // ------------------------------------------------------------------
    logic       done_valid;
    logic       done_good;
    logic [7:0] done_byte;

    always_ff @(posedge clk) begin
        if (rst) begin
            done_valid <= 1'b0;
            done_good  <= 1'b0;
            done_byte  <= '0;
        end else begin
            done_valid <= stop_sample;
            done_good  <= rxs;
            done_byte  <= shift_reg;
        end
    end

    // ------------------------------------------------------------------
    // FIFO and consumer handshake
    // ------------------------------------------------------------------
    logic       fifo_full;
    logic       fifo_empty;
    logic [7:0] fifo_head;
    logic       pop;
    logic       push_ok;
    logic       drop;

    assign pop     = ~fifo_empty & m.m_ready;
    assign push_ok = done_valid & done_good & (~fifo_full | pop);
    assign drop    = done_valid & done_good & fifo_full & ~pop;

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_ok),
        .push_data (done_byte),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    assign m.m_valid = ~fifo_empty;
    // Storage is not reset; hold the bus at 0 while nothing is queued.
    assign m.m_data  = fifo_empty ? 8'h00 : fifo_head;

    // ------------------------------------------------------------------
    // Flags and line counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err <= 1'b0;
            overflow  <= 1'b0;
            line_cnt  <= '0;
        end else begin
            frame_err <= done_valid & ~done_good;

            // A new drop wins over a same-cycle clear.
            if (drop)     overflow <= 1'b1;
            else if (clr) overflow <= 1'b0;

            // A clear wins over a same-cycle line feed.
            if (clr)                                    line_cnt <= '0;
            else if (push_ok && done_byte == ASCII_LF)  line_cnt <= line_cnt + 16'd1;
        end
    end

endmodule
